// File: rtl/phase_reader_pkg.sv
// rtl/phase_reader_pkg.sv - shared types, UART constants and hex helper for the phase tag reader
package phase_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        START,
        DATA,
        STOP
    } reader_state_t;

    localparam logic       UART_START_BIT = 1'b0;
    localparam logic       UART_STOP_BIT  = 1'b1;
    localparam logic [7:0] UART_NEWLINE   = 8'h0A;

    // 0-9 -> '0'-'9', A-F -> 'A'-'F' (uppercase)
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return {4'h3, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 LSB-first byte serializer with per-bit baud reload
//
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   start, data      load a byte and begin its start bit on the next cycle
//   tx               serial line, idle high (registered)
//   busy             a frame is in progress
//   bit_end          last cycle of the current bit
//   bit_idx          0 = start bit, 1..8 = data bits, 9 = stop bit
//   done             last cycle of the stop bit
// A start on the done cycle chains the next frame with no idle cycle.
module uart_tx_byte
    import phase_reader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       bit_end,
    output logic [3:0] bit_idx,
    output logic       done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic [BAUD_W-1:0] baud_cnt;
    logic [7:0]        shift;

    assign bit_end = busy && (baud_cnt == BAUD_LAST);
    assign done    = bit_end && (bit_idx == 4'd9);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx       <= UART_STOP_BIT;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else if (start) begin
            tx       <= UART_START_BIT;
            busy     <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= data;
        end else if (busy) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    busy    <= 1'b0;
                    tx      <= UART_STOP_BIT;
                    bit_idx <= '0;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    if (bit_idx == 4'd8) begin
                        tx <= UART_STOP_BIT;
                    end else begin
                        tx    <= shift[0];
                        shift <= {1'b0, shift[7:1]};
                    end
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/phase_tag_uart_reader.sv
// rtl/phase_tag_uart_reader.sv - drains phase tags from the FIFO read side onto a UART TX line
//
// Ports:
//   clk_read, rst_n  read-domain clock, synchronous active-low reset
//   tx_en            allow new tags to start; an active tag always completes
//   fifo_data        FIFO Q, valid RD_LATENCY cycles after fifo_rd_en
//   fifo_empty       FIFO empty flag, sampled only in IDLE
//   fifo_rd_en       one-cycle read strobe per tag
//   uart_tx          8N1 serial output, idle high
//   busy             low only in IDLE
//   tags_sent        completed tag count, wraps
// Build option PHASE_TAG_HEX_ASCII_EN: each tag goes out as two uppercase
// hex characters and a newline, chained without idle cycles.
module phase_tag_uart_reader
    import phase_reader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int RD_LATENCY   = 1,
    parameter int COUNT_W      = 16
) (
    input  logic               clk_read,
    input  logic               rst_n,
    input  logic               tx_en,
    input  logic [7:0]         fifo_data,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    output logic               uart_tx,
    output logic               busy,
    output logic [COUNT_W-1:0] tags_sent
);

    localparam logic [1:0] CAP_LAST = 2'(RD_LATENCY - 1);

    reader_state_t state;
    logic [1:0]    cap_cnt;
    logic          cap_last;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
    logic          tx_bit_end;
    logic [3:0]    tx_bit_idx;
    logic          tx_done;

    // fifo_data is consumed straight off the FIFO on the last CAP cycle
    assign cap_last = (state == CAP) && (cap_cnt == CAP_LAST);

`ifdef PHASE_TAG_HEX_ASCII_EN
    logic [1:0] char_idx;
    logic [3:0] lo_nib;

    assign tx_start = cap_last || ((state == STOP) && tx_done && (char_idx != 2'd2));
    always_comb begin
        tx_data = UART_NEWLINE;
        if (cap_last) begin
            tx_data = nibble_to_ascii(fifo_data[7:4]);
        end else if (char_idx == 2'd0) begin
            tx_data = nibble_to_ascii(lo_nib);
        end
    end
`else
    assign tx_start = cap_last;
    assign tx_data  = fifo_data;
`endif

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk     (clk_read),
        .rst_n   (rst_n),
        .start   (tx_start),
        .data    (tx_data),
        .tx      (uart_tx),
        .busy    (tx_busy),
        .bit_end (tx_bit_end),
        .bit_idx (tx_bit_idx),
        .done    (tx_done)
    );

    always_ff @(posedge clk_read) begin
        if (!rst_n) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            tags_sent  <= '0;
            cap_cnt    <= '0;
`ifdef PHASE_TAG_HEX_ASCII_EN
            char_idx   <= '0;
            lo_nib     <= '0;
`endif
        end else begin
            fifo_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_en && !fifo_empty && !tx_busy) begin
                        state      <= RD;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                RD: begin
                    state   <= CAP;
                    cap_cnt <= '0;
                end
                CAP: begin
                    if (cap_last) begin
                        state <= START;
`ifdef PHASE_TAG_HEX_ASCII_EN
                        lo_nib   <= fifo_data[3:0];
                        char_idx <= '0;
`endif
                    end else begin
                        cap_cnt <= cap_cnt + 2'd1;
                    end
                end
                START: begin
                    if (tx_bit_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tx_bit_end && (tx_bit_idx == 4'd8)) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (tx_done) begin
`ifdef PHASE_TAG_HEX_ASCII_EN
                        if (char_idx == 2'd2) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            tags_sent <= tags_sent + 1'b1;
                            char_idx  <= '0;
                        end else begin
                            state    <= START;
                            char_idx <= char_idx + 2'd1;
                        end
`else
                        state     <= IDLE;
                        busy      <= 1'b0;
                        tags_sent <= tags_sent + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_tag_uart_reader.sv
// tb/tb_phase_tag_uart_reader.sv - directed self-checking bench for phase_tag_uart_reader
module tb_phase_tag_uart_reader;

    logic        clk;
    logic        rst_n;
    logic        tx_en;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        uart_tx;
    logic        busy;
    logic [15:0] tags_sent;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int rd_cyc = -100;
    int underflow = 0;
    int push_cnt = 0;
    int pop_cnt = 0;
    logic [7:0] mem [0:63];

    phase_tag_uart_reader #(
        .CLKS_PER_BIT(4),
        .RD_LATENCY  (1),
        .COUNT_W     (16)
    ) dut (
        .clk_read  (clk),
        .rst_n     (rst_n),
        .tx_en     (tx_en),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .tags_sent (tags_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = (push_cnt == pop_cnt);

    // FIFO model with one cycle of registered read latency
    initial fifo_data = 8'h00;
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (fifo_rd_en) begin
            rd_cnt = rd_cnt + 1;
            rd_cyc = cyc - 1;
            if (push_cnt == pop_cnt) begin
                underflow = underflow + 1;
            end else begin
                fifo_data <= mem[pop_cnt];
                pop_cnt = pop_cnt + 1;
            end
        end
    end

    task automatic push(input logic [7:0] v);
        mem[push_cnt] = v;
        push_cnt = push_cnt + 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int s);
        bit seen;
        seen = 1'b0;
        s = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (uart_tx === 1'b0) begin
                seen = 1'b1;
                s = cyc;
            end
        end
        check("start_seen", {31'd0, seen}, 32'd1);
    endtask

    // Called on the first START sample; collects the rest of a 40-cycle frame
    task automatic recv_byte(input int drop_at, output logic [7:0] b, output logic shape_ok);
        logic samp [0:39];
        samp[0] = uart_tx;
        shape_ok = 1'b1;
        for (int k = 1; k < 40; k++) begin
            tick();
            samp[k] = uart_tx;
            if (busy !== 1'b1) shape_ok = 1'b0;
            if (k == drop_at) tx_en = 1'b0;
        end
        for (int j = 0; j < 10; j++) begin
            for (int m = 1; m < 4; m++) begin
                if (samp[4*j+m] !== samp[4*j]) shape_ok = 1'b0;
            end
        end
        if (samp[0] !== 1'b0 || samp[36] !== 1'b1) shape_ok = 1'b0;
        for (int j = 0; j < 8; j++) b[j] = samp[4*(j+1)];
    endtask

    typedef struct {
        logic [7:0] tag;
        logic [7:0] exp_byte;
        int         exp_count;
    } vec_t;

    vec_t vecs [0:3];

    initial begin
        int s;
        int prev_end;
        int base_rd;
        int c;
        logic [7:0] b;
        logic sh;

        vecs[0] = '{8'hA5, 8'hA5, 1};
        vecs[1] = '{8'h01, 8'h01, 2};
        vecs[2] = '{8'h80, 8'h80, 3};
        vecs[3] = '{8'hFF, 8'hFF, 4};

        rst_n = 1'b0;
        tx_en = 1'b1;
        push(8'h96);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
            check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_tags", {16'd0, tags_sent}, 32'd0);
        end
        rst_n = 1'b1;

        // frame for 0x96 is cut by reset in data bit 1 and must not be counted
        wait_start(s);
        check("pre_rst_latency", s - rd_cyc, 32'd2);
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("midrst_uart_tx", {31'd0, uart_tx}, 32'd1);
            check("midrst_busy", {31'd0, busy}, 32'd0);
            check("midrst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
            check("midrst_tags", {16'd0, tags_sent}, 32'd0);
        end

`ifndef PHASE_TAG_HEX_ASCII_EN
        for (int i = 0; i < 4; i++) push(vecs[i].tag);
        rst_n = 1'b1;
        base_rd = rd_cnt;
        prev_end = 0;
        for (int i = 0; i < 4; i++) begin
            wait_start(s);
            check("start_latency", s - rd_cyc, 32'd2);
            if (i > 0) check("inter_tag_gap", s - prev_end - 1, 32'd3);
            recv_byte(-1, b, sh);
            check("rx_byte", {24'd0, b}, {24'd0, vecs[i].exp_byte});
            check("frame_shape", {31'd0, sh}, 32'd1);
            prev_end = s + 39;
            tick();
            check("tags_after_frame", {16'd0, tags_sent}, vecs[i].exp_count);
        end
        check("rd_pulses", rd_cnt - base_rd, 32'd4);
        for (int i = 0; i < 20; i++) tick();
        check("no_rd_when_empty", rd_cnt - base_rd, 32'd4);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_uart_tx", {31'd0, uart_tx}, 32'd1);

        // tx_en dropped during data bit 3 with two tags queued
        push(8'h5A);
        push(8'hC3);
        wait_start(s);
        check("txen_latency", s - rd_cyc, 32'd2);
        recv_byte(16, b, sh);
        check("txen_rx_byte", {24'd0, b}, 32'h5A);
        check("txen_shape", {31'd0, sh}, 32'd1);
        base_rd = rd_cnt;
        tick();
        check("txen_tags", {16'd0, tags_sent}, 32'd5);
        for (int i = 0; i < 10; i++) tick();
        check("no_rd_while_disabled", rd_cnt - base_rd, 32'd0);
        check("disabled_busy", {31'd0, busy}, 32'd0);
        tx_en = 1'b1;
        c = cyc;
        wait_start(s);
        check("resume_rd_cycle", rd_cyc - c, 32'd1);
        check("resume_latency", s - rd_cyc, 32'd2);
        recv_byte(-1, b, sh);
        check("resume_rx_byte", {24'd0, b}, 32'hC3);
        tick();
        check("resume_tags", {16'd0, tags_sent}, 32'd6);
`else
        push(8'h3C);
        rst_n = 1'b1;
        base_rd = rd_cnt;
        wait_start(s);
        check("hex_latency", s - rd_cyc, 32'd2);
        recv_byte(-1, b, sh);
        check("hex_char0", {24'd0, b}, 32'h33);
        check("hex_shape0", {31'd0, sh}, 32'd1);
        prev_end = s;
        wait_start(s);
        check("hex_contig1", s - prev_end, 32'd40);
        check("hex_tags_mid1", {16'd0, tags_sent}, 32'd0);
        recv_byte(-1, b, sh);
        check("hex_char1", {24'd0, b}, 32'h43);
        check("hex_shape1", {31'd0, sh}, 32'd1);
        prev_end = s;
        wait_start(s);
        check("hex_contig2", s - prev_end, 32'd40);
        check("hex_tags_mid2", {16'd0, tags_sent}, 32'd0);
        recv_byte(-1, b, sh);
        check("hex_char2", {24'd0, b}, 32'h0A);
        check("hex_shape2", {31'd0, sh}, 32'd1);
        tick();
        check("hex_tags_done", {16'd0, tags_sent}, 32'd1);
        check("hex_rd_pulses", rd_cnt - base_rd, 32'd1);
`endif
        check("underflow_reads", underflow, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
